// File: rtl/i2c_target_responder_if.sv
// i2c_target_responder_if
//   Bus-side bundle of the I2C target responder: raw SCL/SDA levels in,
//   open-drain SDA pull-down out, plus the byte-level write/read handshake.
//   Signals:
//     scl_in, sda_in  bus levels (asynchronous to clk)
//     sda_oe          1 = target pulls SDA low
//     rx_data/rx_valid  written byte and its 1-clk strobe
//     tx_data/tx_req    next read byte and its 1-clk request strobe
//     busy            target is addressed
//   Modports: master = bus/host side, slave = the target.
interface i2c_target_responder_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;

  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, busy
  );

  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, busy
  );
endinterface

// File: rtl/i2c_target_responder.sv
// i2c_target_responder
//   I2C target end of the bus (SHT40 stand-in). Synchronises SCL/SDA,
//   detects START/STOP, ACKs its 7-bit address, delivers written bytes on
//   rx_data/rx_valid and shifts out read bytes fetched from tx_data,
//   requesting each one with tx_req.
//   Parameters: TGT_ADDR (7-bit address), SYNC_STAGES (>=2 synchroniser flops).
//   Ports: clk, rst (synchronous, active high), bus (slave modport of
//   i2c_target_responder_if).
//   Build option: define I2C_CRC8_EN to insert a Sensirion CRC-8 byte
//   (poly 0x31, init 0xFF) after every two read bytes; that byte is
//   generated internally and gets no tx_req.
module i2c_target_responder #(
  parameter logic [6:0]  TGT_ADDR    = 7'h44,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                   clk,
  input logic                   rst,
  i2c_target_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX,
    S_RX_ACK,
    S_TX,
    S_M_ACK
  } state_t;

  // Synchroniser and edge history are deliberately not reset: after a
  // mid-transfer reset they keep tracking the live bus, so no phantom edge
  // (and hence no false START) is seen when reset releases.
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;

  always_ff @(posedge clk) begin
    scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
    sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
    scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
    sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
  end

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_full_q, byte_full_d;  // 8 bits shifted, waiting for the ACK-slot fall
  logic       ack_q, ack_d;              // master ACKed the last read byte
  logic       rw_q, rw_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;

  logic       load_tx;
  logic       next_is_crc;
  logic [7:0] tx_next;
  logic [7:0] shift_in;

  assign shift_in = {shift_q[6:0], sda_s};

`ifdef I2C_CRC8_EN
  logic [7:0] crc_q, crc_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;  // position of the next read byte within its triple

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    end
    return c;
  endfunction

  assign next_is_crc = (byte_cnt_q == 2'd2);
  assign tx_next     = next_is_crc ? crc_q : bus.tx_data;
`else
  assign next_is_crc = 1'b0;
  assign tx_next     = bus.tx_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      byte_full_q <= 1'b0;
      ack_q       <= 1'b0;
      rw_q        <= 1'b0;
      shift_q     <= '0;
      tx_shift_q  <= '0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef I2C_CRC8_EN
      crc_q       <= '1;
      byte_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_full_q <= byte_full_d;
      ack_q       <= ack_d;
      rw_q        <= rw_d;
      shift_q     <= shift_d;
      tx_shift_q  <= tx_shift_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      busy_q      <= busy_d;
`ifdef I2C_CRC8_EN
      crc_q       <= crc_d;
      byte_cnt_q  <= byte_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_full_d = byte_full_q;
    ack_d       = ack_q;
    rw_d        = rw_q;
    shift_d     = shift_q;
    tx_shift_d  = tx_shift_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    busy_d      = busy_q;
    load_tx     = 1'b0;
`ifdef I2C_CRC8_EN
    crc_d       = crc_q;
    byte_cnt_d  = byte_cnt_q;
`endif

    if (start_det) begin
      state_d     = S_ADDR;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = '0;
      byte_full_d = 1'b0;
      ack_d       = 1'b0;
`ifdef I2C_CRC8_EN
      crc_d       = '1;
      byte_cnt_d  = '0;
`endif
    end else if (stop_det) begin
      state_d     = S_IDLE;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      bit_cnt_d   = '0;
      byte_full_d = 1'b0;
      ack_d       = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;

        S_ADDR: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_full_d = 1'b1;
          end else if (scl_fall && byte_full_q) begin
            byte_full_d = 1'b0;
            if (shift_q[7:1] == TGT_ADDR) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shift_q[0];
              tx_req_d = shift_q[0];
              state_d  = S_ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
        end

        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (!rw_q) begin
              sda_oe_d = 1'b0;
              state_d  = S_RX;
            end else begin
              load_tx  = 1'b1;
              sda_oe_d = ~tx_next[7];
              state_d  = S_TX;
            end
          end
        end

        S_RX: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_full_d = 1'b1;
              rx_data_d   = shift_in;
              rx_valid_d  = 1'b1;
            end
          end else if (scl_fall && byte_full_q) begin
            byte_full_d = 1'b0;
            sda_oe_d    = 1'b1;
            state_d     = S_RX_ACK;
          end
        end

        S_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = S_RX;
          end
        end

        // bit_cnt counts falls here: falls 1..7 put out bits 6..0,
        // the 8th fall frees the line for the master's ACK.
        S_TX: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = S_M_ACK;
            end else begin
              sda_oe_d   = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
          end
        end

        S_M_ACK: begin
          if (scl_rise && !ack_q) begin
            if (sda_s) begin
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
              state_d  = S_IDLE;
            end else begin
              ack_d    = 1'b1;
              tx_req_d = ~next_is_crc;
            end
          end else if (scl_fall && ack_q) begin
            ack_d     = 1'b0;
            load_tx   = 1'b1;
            sda_oe_d  = ~tx_next[7];
            bit_cnt_d = '0;
            state_d   = S_TX;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    if (load_tx) tx_shift_d = tx_next;

`ifdef I2C_CRC8_EN
    // CRC runs over the data bytes as they are latched; emitting the CRC
    // byte itself restarts the checksum for the next pair.
    if (load_tx) begin
      if (next_is_crc) begin
        crc_d      = '1;
        byte_cnt_d = '0;
      end else begin
        crc_d      = crc8_byte(crc_q, bus.tx_data);
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end
`endif
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_req   = tx_req_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// tb_i2c_target_responder
//   Bus-master bench for i2c_target_responder: drives SCL/SDA at bit level,
//   supplies tx_data on tx_req, and checks ACKs, written bytes, read bytes,
//   request counts and busy against a transaction-level model.
module tb_i2c_target_responder;
  localparam int Q = 6;  // quarter SCL period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  i2c_target_responder_if bus();
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_target_responder #(.TGT_ADDR(7'h44), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_rx = 0, n_req = 0, oe_bad = 0, oe_hi = 0;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] src_q[$];
  logic [7:0] fixed_q[$];
  logic oe_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Host side of the target: watches strobes, hands out read bytes,
  // and flags any SDA pull-down change while SCL is high.
  initial begin
    bus.tx_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (bus.rx_valid) begin
        n_rx++;
        last_rx = bus.rx_data;
      end
      if (bus.tx_req) begin
        n_req++;
        if (src_q.size() > 0) bus.tx_data = src_q.pop_front();
        else bus.tx_data = 8'($urandom);
      end
      if (bus.sda_oe !== oe_prev && scl_m && !rst) oe_bad++;
      if (bus.sda_oe) oe_hi++;
      oe_prev = bus.sda_oe;
    end
  end

  function automatic logic [7:0] next_byte();
    if (fixed_q.size() > 0) return fixed_q.pop_front();
    return 8'($urandom);
  endfunction

  function automatic bit is_crc(input int k);
`ifdef I2C_CRC8_EN
    return (k % 3) == 2;
`else
    return 1'b0;
`endif
  endfunction

  // CRC-8 as polynomial long division of {a,b} (init folded into a) by x^8+x^5+x^4+1.
  function automatic logic [7:0] crc_ref(input logic [7:0] a, input logic [7:0] b);
    logic [23:0] v;
    v = {a, b, 8'h00} ^ 24'hFF0000;
    for (int i = 23; i >= 8; i--)
      if (v[i]) v = v ^ (24'h131 << (i - 8));
    return v[7:0];
  endfunction

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q();
    r = bus.sda_in; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
    end
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic recv_byte(input logic last, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(last, r);
  endtask

  task automatic xfer(input logic [6:0] addr, input logic rw, input int n, input logic do_stop);
    logic match;
    logic ack;
    logic [7:0] d;
    logic [7:0] exp_q[$];
    int rx0, req0, oe0, exp_req;
    match = (addr == 7'h44);
    rx0 = n_rx; req0 = n_req; oe0 = oe_hi; exp_req = 0;
    if (rw && match) begin
      for (int k = 0; k < n; k++) begin
        if (is_crc(k)) exp_q.push_back(crc_ref(exp_q[k-2], exp_q[k-1]));
        else begin
          d = next_byte();
          src_q.push_back(d);
          exp_q.push_back(d);
          exp_req++;
        end
      end
    end
    i2c_start();
    send_byte({addr, rw}, ack);
    check("addr_ack", ack, match);
    check("busy_addr", bus.busy, match);
    if (!rw) begin
      for (int k = 0; k < n; k++) begin
        d = next_byte();
        send_byte(d, ack);
        check("wr_ack", ack, match);
        if (match) check("rx_data", last_rx, d);
      end
      check("rx_count", n_rx - rx0, match ? n : 0);
    end else if (match) begin
      for (int k = 0; k < n; k++) begin
        recv_byte(k == n - 1, d);
        check("rd_byte", d, exp_q[k]);
      end
      check("tx_req_count", n_req - req0, exp_req);
    end
    if (!match) check("oe_on_miss", oe_hi - oe0, 0);
    if (do_stop) begin
      i2c_stop();
      check("busy_stop", bus.busy, 1'b0);
      check("oe_stop", bus.sda_oe, 1'b0);
    end
  endtask

  initial begin
    logic ack, r;
    int rx0, req0, oe0;

    repeat (5) @(posedge clk);
    #1;
    check("rst_sda_oe", bus.sda_oe, 1'b0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_tx_req", bus.tx_req, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    @(negedge clk) rst = 1'b0;
    wait_q();

    // write 0xFD to 0x44
    fixed_q = '{8'hFD};
    xfer(7'h44, 1'b0, 1, 1'b1);
    // address miss (0x46)
    xfer(7'h46, 1'b0, 1, 1'b1);
    // read three bytes: BE, EF, then tx_data or CRC
    fixed_q = '{8'hBE, 8'hEF, 8'h5A};
    xfer(7'h44, 1'b1, 3, 1'b1);
    fixed_q.delete();
    // write, repeated START, read
    fixed_q = '{8'hFD};
    xfer(7'h44, 1'b0, 1, 1'b0);
    xfer(7'h44, 1'b1, 2, 1'b1);

    // STOP after 4 bits of a write byte
    i2c_start();
    send_byte(8'h88, ack);
    check("t5_addr_ack", ack, 1'b1);
    rx0 = n_rx;
    for (int i = 0; i < 4; i++) bit_xfer(1'($urandom), r);
    i2c_stop();
    check("t5_rx_count", n_rx - rx0, 0);
    check("t5_oe", bus.sda_oe, 1'b0);
    check("t5_busy", bus.busy, 1'b0);
    xfer(7'h44, 1'b0, 1, 1'b1);

    // reset while the target drives a 0 bit
    src_q.push_back(8'h00);
    i2c_start();
    send_byte(8'h89, ack);
    check("t6_addr_ack", ack, 1'b1);
    check("t6_drive0", bus.sda_oe, 1'b1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_oe_after_rst", bus.sda_oe, 1'b0);
    check("t6_busy_after_rst", bus.busy, 1'b0);
    @(negedge clk) rst = 1'b0;
    rx0 = n_rx; req0 = n_req; oe0 = oe_hi;
    for (int i = 0; i < 9; i++) bit_xfer(1'b1, r);
    check("t6_oe_ignored", oe_hi - oe0, 0);
    check("t6_req_ignored", n_req - req0, 0);
    check("t6_rx_ignored", n_rx - rx0, 0);
    i2c_stop();
    xfer(7'h44, 1'b0, 1, 1'b1);

    // randomized transactions
    for (int it = 0; it < 20; it++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 1) == 0) ? 7'h44 : 7'($urandom);
      xfer(a, 1'($urandom), $urandom_range(1, 4), (it == 19) || ($urandom_range(0, 3) != 0));
    end

    check("oe_stable_scl_high", oe_bad, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
